qsfp_mgmt_ctrl: RTL and testbench

Sequences the QSFP28 cage on the VCU118: refclk reset, module presence detection, module reset/initialisation timing and low-power control. Holds the Ethernet MAC/PHY in reset until the module is ready. Sits beside the Ethernet subsystem in the board wrapper and drives the QSFP sideband pins (modsell, resetl, lpmode, refclk_reset, fs). Gives the RISC-V side presence, ready and interrupt status plus restart and low-power controls.

---
 rtl/qsfp_mgmt_pkg.sv | 39 +++
 rtl/qsfp_debounce.sv | 40 ++++
 rtl/qsfp_mgmt_ctrl.sv | 129 ++++++++++++
 tb/tb_qsfp_mgmt_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qsfp_mgmt_pkg.sv
// Shared state encodings, 125 MHz timing defaults and the pin decode for the QSFP28 manager.
package qsfp_mgmt_pkg;

   typedef enum logic [2:0] {
      REFCLK_RST = 3'd0,
      ABSENT     = 3'd1,
      MOD_RESET  = 3'd2,
      MOD_INIT   = 3'd3,
      READY      = 3'd4
   } mgmt_state_t;

   localparam int REFCLK_CYCLES_DEF   = 125;
   localparam int RESET_CYCLES_DEF    = 1250;
   localparam int INIT_CYCLES_DEF     = 250000000;
   localparam int DEBOUNCE_CYCLES_DEF = 125000;
   localparam int CNT_W_DEF           = 28;

   typedef struct packed {
      logic refclk_reset;
      logic resetl;
      logic lpmode;
      logic modsell;
      logic eth_reset;
      logic ready;
   } pin_out_t;

   // Anything short of READY keeps the module held low-power and the MAC in reset.
   function automatic pin_out_t decode_outputs(input mgmt_state_t st, input logic lp_req);
      pin_out_t po;
      po.refclk_reset = (st == REFCLK_RST);
      po.resetl       = (st == MOD_INIT) || (st == READY);
      po.lpmode       = (st == READY) ? lp_req : 1'b1;
      po.modsell      = (st != READY);
      po.eth_reset    = (st != READY);
      po.ready        = (st == READY);
      return po;
   endfunction

endpackage

// File: rtl/qsfp_debounce.sv
// Two-flop synchroniser plus stability counter; output follows the pin only after a sustained change.
module qsfp_debounce
   import qsfp_mgmt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1, sync_2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         dout   <= 1'b1;
         cnt    <= '0;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
         // Any sample that agrees with the held value restarts the count.
         if (sync_2 == dout) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            dout <= sync_2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP28 cage sequencer: refclk reset, presence debounce, module reset/init timing, MAC reset gating.
module qsfp_mgmt_ctrl
   import qsfp_mgmt_pkg::*;
#(
   parameter int         REFCLK_CYCLES   = REFCLK_CYCLES_DEF,
   parameter int         RESET_CYCLES    = RESET_CYCLES_DEF,
   parameter int         INIT_CYCLES     = INIT_CYCLES_DEF,
   parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int         CNT_W           = CNT_W_DEF,
   parameter logic [1:0] FS_SEL          = 2'b00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       qsfp_modprsl,
   input  logic       qsfp_intl,
   output logic       qsfp_modsell,
   output logic       qsfp_resetl,
   output logic       qsfp_lpmode,
   output logic       qsfp_refclk_reset,
   output logic [1:0] qsfp_fs,
   input  logic       restart,
   input  logic       lpmode_req,
   input  logic       irq_clear,
   output logic       eth_reset,
   output logic       module_present,
   output logic       module_ready,
   output logic       irq,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] REFCLK_LAST = CNT_W'(REFCLK_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);

   assign qsfp_fs = FS_SEL;

   logic modprsl_db;

   qsfp_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_modprsl_db (
      .clock (clock),
      .reset (reset),
      .din   (qsfp_modprsl),
      .dout  (modprsl_db)
   );

   logic intl_s1, intl_s2, intl_d;
   logic intl_fall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         intl_s1 <= 1'b1;
         intl_s2 <= 1'b1;
         intl_d  <= 1'b1;
      end else begin
         intl_s1 <= qsfp_intl;
         intl_s2 <= intl_s1;
         intl_d  <= intl_s2;
      end
   end

   assign intl_fall = intl_d & ~intl_s2;

   mgmt_state_t      cur, nxt;
   logic [CNT_W-1:0] timer;
   logic             timer_clr;
   logic             irq_set;
   pin_out_t         po;

   assign cur = mgmt_state_t'(state);

   always_comb begin
      nxt       = cur;
      timer_clr = 1'b0;
      case (cur)
         REFCLK_RST: if (timer == REFCLK_LAST) nxt = ABSENT;
         ABSENT:     if (module_present) nxt = MOD_RESET;
         MOD_RESET, MOD_INIT, READY: begin
            if (!module_present) begin
               nxt = ABSENT;
            end else if (restart) begin
               // Restart from MOD_RESET itself must still re-arm the full reset width.
               nxt       = MOD_RESET;
               timer_clr = 1'b1;
            end else if (cur == MOD_RESET && timer == RESET_LAST) begin
               nxt = MOD_INIT;
            end else if (cur == MOD_INIT && timer == INIT_LAST) begin
               nxt = READY;
            end
         end
         default:    nxt = REFCLK_RST;
      endcase
      if (nxt != cur) timer_clr = 1'b1;
   end

   assign po      = decode_outputs(nxt, lpmode_req);
   assign irq_set = ((cur != REFCLK_RST) && (module_present == modprsl_db)) ||
                    ((cur == READY) && intl_fall);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= REFCLK_RST;
         timer             <= '0;
         module_present    <= 1'b0;
         irq               <= 1'b0;
         qsfp_refclk_reset <= 1'b1;
         qsfp_resetl       <= 1'b0;
         qsfp_lpmode       <= 1'b1;
         qsfp_modsell      <= 1'b1;
         eth_reset         <= 1'b1;
         module_ready      <= 1'b0;
      end else begin
         state             <= nxt;
         timer             <= timer_clr ? '0 : timer + 1'b1;
         module_present    <= ~modprsl_db;
         qsfp_refclk_reset <= po.refclk_reset;
         qsfp_resetl       <= po.resetl;
         qsfp_lpmode       <= po.lpmode;
         qsfp_modsell      <= po.modsell;
         eth_reset         <= po.eth_reset;
         module_ready      <= po.ready;
         if (irq_set)        irq <= 1'b1;
         else if (irq_clear) irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Bench for qsfp_mgmt_ctrl with shortened timing; table-driven bring-up plus hand sequences.
module tb_qsfp_mgmt_ctrl;

   localparam logic [1:0] TB_FS = 2'b10;
   localparam logic [2:0] S_REF = 3'd0, S_ABS = 3'd1, S_RST = 3'd2, S_INI = 3'd3, S_RDY = 3'd4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       qsfp_modprsl = 1'b1, qsfp_intl = 1'b1;
   logic       restart = 1'b0, lpmode_req = 1'b0, irq_clear = 1'b0;
   logic       qsfp_modsell, qsfp_resetl, qsfp_lpmode, qsfp_refclk_reset;
   logic [1:0] qsfp_fs;
   logic       eth_reset, module_present, module_ready, irq;
   logic [2:0] state;

   qsfp_mgmt_ctrl #(
      .REFCLK_CYCLES (4), .RESET_CYCLES (8), .INIT_CYCLES (16),
      .DEBOUNCE_CYCLES (4), .CNT_W (8), .FS_SEL (TB_FS)
   ) dut (
      .clock (clock), .reset (reset),
      .qsfp_modprsl (qsfp_modprsl), .qsfp_intl (qsfp_intl),
      .qsfp_modsell (qsfp_modsell), .qsfp_resetl (qsfp_resetl),
      .qsfp_lpmode (qsfp_lpmode), .qsfp_refclk_reset (qsfp_refclk_reset),
      .qsfp_fs (qsfp_fs), .restart (restart), .lpmode_req (lpmode_req),
      .irq_clear (irq_clear), .eth_reset (eth_reset),
      .module_present (module_present), .module_ready (module_ready),
      .irq (irq), .state (state)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic [12:0] v;
   } vec_t;

   vec_t        vt[10];
   logic [12:0] sb_q[$];
   logic [12:0] dut_vec;
   int          total = 0, bad = 0, cyc = -1;

   assign dut_vec = {state, qsfp_refclk_reset, qsfp_resetl, qsfp_lpmode, qsfp_modsell,
                     eth_reset, module_present, module_ready, irq, qsfp_fs};

   function automatic logic [12:0] ov(input logic [2:0] st, input logic rc, rl, lp, ms,
                                      eth, pr, rd, iq);
      return {st, rc, rl, lp, ms, eth, pr, rd, iq, TB_FS};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic sb_pop(input string nm);
      if (sb_q.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         chk(nm, 32'(dut_vec), 32'(sb_q.pop_front()));
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   // Reset lands mid-cycle, so the reset values are checked before any clock edge.
   task automatic apply_reset();
      #2 reset = 1'b1;
      #1 chk("async_rst", 32'(dut_vec), 32'(ov(S_REF, 1, 0, 1, 1, 1, 0, 0, 0)));
      repeat (2) @(negedge clock);
      reset = 1'b0;
      cyc   = -1;
   endtask

   task automatic run_table();
      int idx = 0;
      for (int c = 0; c <= 31; c++) begin
         logic pend = 1'b0;
         if (idx < 10 && vt[idx].cyc == c) begin
            sb_q.push_back(vt[idx].v);
            pend = 1'b1;
            idx++;
         end
         step();
         if (pend) sb_pop($sformatf("seq_c%0d", c));
      end
   endtask

   initial begin
      int rst_n, ini_n;
      vt[0] = '{0,  ov(S_REF, 1, 0, 1, 1, 1, 0, 0, 0)};
      vt[1] = '{2,  ov(S_REF, 1, 0, 1, 1, 1, 0, 0, 0)};
      vt[2] = '{3,  ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 0)};
      vt[3] = '{5,  ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 0)};
      vt[4] = '{6,  ov(S_ABS, 0, 0, 1, 1, 1, 1, 0, 1)};
      vt[5] = '{7,  ov(S_RST, 0, 0, 1, 1, 1, 1, 0, 1)};
      vt[6] = '{14, ov(S_RST, 0, 0, 1, 1, 1, 1, 0, 1)};
      vt[7] = '{15, ov(S_INI, 0, 1, 1, 1, 1, 1, 0, 1)};
      vt[8] = '{30, ov(S_INI, 0, 1, 1, 1, 1, 1, 0, 1)};
      vt[9] = '{31, ov(S_RDY, 0, 1, 0, 0, 0, 1, 1, 1)};

      // Module absent throughout, with a short presence glitch.
      #1;
      qsfp_modprsl = 1'b1;
      apply_reset();
      repeat (8) step();
      chk("absent_hold", 32'(dut_vec), 32'(ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 0)));
      qsfp_modprsl = 1'b0;
      repeat (3) step();
      qsfp_modprsl = 1'b1;
      repeat (10) step();
      chk("glitch_ignored", 32'(dut_vec), 32'(ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 0)));
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_absent", 32'(dut_vec), 32'(ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 0)));

      // Module present from reset: full bring-up.
      qsfp_modprsl = 1'b0;
      apply_reset();
      run_table();

      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("irq_clear", 32'(irq), 32'd0);

      qsfp_intl = 1'b0;
      repeat (2) step();
      chk("intl_sync_lat", 32'(irq), 32'd0);
      step();
      chk("intl_irq", 32'(irq), 32'd1);
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("irq_clear2", 32'(irq), 32'd0);

      qsfp_intl = 1'b1;
      repeat (4) step();
      qsfp_intl = 1'b0;
      repeat (2) step();
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("set_wins_clear", 32'(irq), 32'd1);
      irq_clear = 1'b1;
      step();
      irq_clear = 1'b0;
      chk("irq_clear3", 32'(irq), 32'd0);

      lpmode_req = 1'b1;
      chk("lp_pre", 32'(qsfp_lpmode), 32'd0);
      step();
      chk("lp_on", 32'(qsfp_lpmode), 32'd1);
      lpmode_req = 1'b0;
      step();
      chk("lp_off", 32'(qsfp_lpmode), 32'd0);

      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_entry", 32'(dut_vec), 32'(ov(S_RST, 0, 0, 1, 1, 1, 1, 0, 0)));
      rst_n = 1;
      ini_n = 0;
      for (int i = 0; i < 60 && state != S_RDY; i++) begin
         step();
         if (state == S_RST)      rst_n++;
         else if (state == S_INI) ini_n++;
      end
      chk("restart_rst_len", 32'(rst_n), 32'd8);
      chk("restart_init_len", 32'(ini_n), 32'd16);
      chk("restart_ready", 32'(dut_vec), 32'(ov(S_RDY, 0, 1, 0, 0, 0, 1, 1, 0)));

      // Module pulled for 6 cycles while READY.
      qsfp_modprsl = 1'b1;
      repeat (6) step();
      qsfp_modprsl = 1'b0;
      step();
      chk("loss_present", 32'(dut_vec), 32'(ov(S_RDY, 0, 1, 0, 0, 0, 0, 1, 1)));
      step();
      chk("loss_absent", 32'(dut_vec), 32'(ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 1)));
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("loss_restart_ign", 32'(dut_vec), 32'(ov(S_ABS, 0, 0, 1, 1, 1, 0, 0, 1)));
      for (int i = 0; i < 100 && !module_ready; i++) step();
      chk("reready", 32'(dut_vec), 32'(ov(S_RDY, 0, 1, 0, 0, 0, 1, 1, 1)));

      // Async reset in the middle of MOD_INIT, then a full re-run.
      restart = 1'b1;
      step();
      restart = 1'b0;
      repeat (10) step();
      chk("mid_init_state", 32'(state), 32'(S_INI));
      apply_reset();
      run_table();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
